// File: rtl/collision_event_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the collision event scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    // Number of collision sources (fixed in this revision)
    localparam int NUM_SRC = 3;

    // Event codes presented on the event port; code 3 is never produced
    typedef enum logic [1:0] {
        EV_SHOT_BOX   = 2'd0,
        EV_TOWER_HU   = 2'd1,
        EV_SHOT_ENEMY = 2'd2
    } ev_type_e;

    // Next index in the 0 -> 1 -> 2 -> 0 rotation
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/collision_event_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : collision_event_scheduler_if
// Description : Valid/ready event port carrying one collision event per beat.
// Revision    : 1.0 - initial release
// ============================================================================
interface collision_event_scheduler_if;

    logic              event_valid;
    logic              event_ready;
    game_pkg::ev_type_e event_type;

    // Producer side (scheduler)
    modport master (
        output event_valid,
        output event_type,
        input  event_ready
    );

    // Consumer side (score/lives logic)
    modport slave (
        input  event_valid,
        input  event_type,
        output event_ready
    );

endinterface
`default_nettype wire

// File: rtl/collision_event_scheduler_arb.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter3
// Description : Combinational 3-way round-robin arbiter. ptr is the index with
//               highest priority; priority then rotates upward modulo 3.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter3
    import game_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic               gnt_valid,
    output logic [1:0]         gnt_idx
);

    logic [1:0] w_cand0;
    logic [1:0] w_cand1;
    logic [1:0] w_cand2;

    assign w_cand0 = ptr;
    assign w_cand1 = rr_next(ptr);
    assign w_cand2 = rr_next(w_cand1);

    // Pick the first requesting index starting from ptr
    always_comb begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'd0;
        if (req[w_cand0]) begin
            gnt_idx = w_cand0;
        end else if (req[w_cand1]) begin
            gnt_idx = w_cand1;
        end else if (req[w_cand2]) begin
            gnt_idx = w_cand2;
        end else begin
            gnt_valid = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/collision_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : collision_event_scheduler
// Description : Collapses per-pixel collision strobes into at most one hit per
//               source per frame, queues the hits and issues them round-robin
//               on a single valid/ready event port.
//               Optional feature macro: COLLISION_DROP_CNT_EN adds a saturating
//               drop_count output counting hits lost to a still-pending event.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_event_scheduler
    import game_pkg::*;
#(
    parameter int DROP_CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      startOfFrame,
    input  logic                      ShotBoxCollision,
    input  logic                      TowerEnemyHUCollision,
    input  logic                      ShotEnemyCollision,
    collision_event_scheduler_if.master ev_if,
`ifdef COLLISION_DROP_CNT_EN
    output logic [DROP_CNT_W-1:0]     drop_count,
`endif
    output logic [NUM_SRC-1:0]        frame_hits
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // The saturating counter needs room for a 3-drop increment
    if (DROP_CNT_W < 2) begin : g_bad_drop_cnt_w
        $error("DROP_CNT_W must be at least 2");
    end

    logic [NUM_SRC-1:0] w_strobe;
    logic [NUM_SRC-1:0] w_accept;
    logic [NUM_SRC-1:0] w_grant_vec;
    logic               w_gnt_valid;
    logic [1:0]         w_gnt_idx;
    logic               w_do_grant;

    logic [NUM_SRC-1:0] fired_q,       fired_d;
    logic [NUM_SRC-1:0] pending_q,     pending_d;
    logic [NUM_SRC-1:0] frame_hits_q,  frame_hits_d;
    logic [1:0]         rr_ptr_q,      rr_ptr_d;
    state_e             state_q,       state_d;
    logic               event_valid_q, event_valid_d;
    ev_type_e           event_type_q,  event_type_d;

    rr_arbiter3 u_arb (
        .req       (pending_q),
        .ptr       (rr_ptr_q),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Hit filtering, pending queue, pointer and event FSM next-state logic
    always_comb begin
        w_strobe = {ShotEnemyCollision, TowerEnemyHUCollision, ShotBoxCollision};

        // A strobe in the frame-start cycle is the first hit of the new frame
        w_accept     = startOfFrame ? w_strobe : (w_strobe & ~fired_q);
        fired_d      = startOfFrame ? w_strobe : (fired_q | w_strobe);
        frame_hits_d = startOfFrame ? fired_q  : frame_hits_q;

        // The event register is free when idle or when its beat is taken now
        w_do_grant  = w_gnt_valid && ((state_q == ST_IDLE) || ev_if.event_ready);
        w_grant_vec = w_do_grant ? (NUM_SRC'(1) << w_gnt_idx) : '0;

        // A hit arriving in its own grant cycle re-arms pending
        pending_d = (pending_q & ~w_grant_vec) | w_accept;
        rr_ptr_d  = w_do_grant ? rr_next(w_gnt_idx) : rr_ptr_q;

        state_d       = state_q;
        event_valid_d = event_valid_q;
        event_type_d  = event_type_q;
        case (state_q)
            ST_IDLE: begin
                if (w_do_grant) begin
                    event_valid_d = 1'b1;
                    event_type_d  = ev_type_e'(w_gnt_idx);
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ev_if.event_ready) begin
                    if (w_do_grant) begin
                        event_type_d = ev_type_e'(w_gnt_idx);
                    end else begin
                        event_valid_d = 1'b0;
                        state_d       = ST_IDLE;
                    end
                end
            end
            default: begin
                event_valid_d = 1'b0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight event
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fired_q       <= '0;
            pending_q     <= '0;
            frame_hits_q  <= '0;
            rr_ptr_q      <= 2'd0;
            state_q       <= ST_IDLE;
            event_valid_q <= 1'b0;
            event_type_q  <= EV_SHOT_BOX;
        end else begin
            fired_q       <= fired_d;
            pending_q     <= pending_d;
            frame_hits_q  <= frame_hits_d;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            event_valid_q <= event_valid_d;
            event_type_q  <= event_type_d;
        end
    end

    assign ev_if.event_valid = event_valid_q;
    assign ev_if.event_type  = event_type_q;
    assign frame_hits        = frame_hits_q;

`ifdef COLLISION_DROP_CNT_EN
    logic [NUM_SRC-1:0]    w_drop;
    logic [DROP_CNT_W:0]   w_drop_sum;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

    // Count hits that land on a source whose previous hit is still queued
    always_comb begin
        w_drop     = w_accept & pending_q & ~w_grant_vec;
        w_drop_sum = {1'b0, drop_count_q};
        for (int i = 0; i < NUM_SRC; i++) begin
            w_drop_sum = w_drop_sum + (DROP_CNT_W + 1)'(w_drop[i]);
        end
        drop_count_d = w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
    end

    // Drop counter register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_collision_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_collision_event_scheduler
// Description : Directed self-checking bench for collision_event_scheduler.
//               Drop-counter scenarios run when COLLISION_DROP_CNT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_event_scheduler;

    logic clk = 1'b0;
    logic resetN;
    logic sof, sb, th, se;
    logic [2:0] frame_hits;
`ifdef COLLISION_DROP_CNT_EN
    logic [7:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    collision_event_scheduler_if ev_if();

    collision_event_scheduler #(.DROP_CNT_W(8)) dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (sof),
        .ShotBoxCollision      (sb),
        .TowerEnemyHUCollision (th),
        .ShotEnemyCollision    (se),
        .ev_if                 (ev_if.master),
`ifdef COLLISION_DROP_CNT_EN
        .drop_count            (drop_count),
`endif
        .frame_hits            (frame_hits)
    );

    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        sof = 0; sb = 0; th = 0; se = 0;
        ev_if.event_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if ({ev_if.event_valid, ev_if.event_type} !== 3'b000) begin
            errors++;
            $display("FAIL reset_event: got %b expected 000", {ev_if.event_valid, ev_if.event_type});
        end
        checks++;
        if (frame_hits !== 3'b000) begin
            errors++;
            $display("FAIL reset_frame_hits: got %b expected 000", frame_hits);
        end
`ifdef COLLISION_DROP_CNT_EN
        checks++;
        if (drop_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_count: got %0d expected 0", drop_count);
        end
`endif
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_single_hit();
        int nvalid;
        ev_if.event_ready = 1'b1;
        se = 1'b1;
        tick();
        checks++;
        if (ev_if.event_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency1: valid got %b expected 0", ev_if.event_valid);
        end
        tick();
        checks++;
        if ({ev_if.event_valid, ev_if.event_type} !== 3'b110) begin
            errors++;
            $display("FAIL single_latency2: got %b expected 110", {ev_if.event_valid, ev_if.event_type});
        end
        nvalid = 1;
        for (int i = 0; i < 42; i++) begin
            if (i == 38) se = 1'b0;
            tick();
            if (ev_if.event_valid === 1'b1) nvalid++;
        end
        checks++;
        if (nvalid != 1) begin
            errors++;
            $display("FAIL single_count: got %0d events expected 1", nvalid);
        end
    endtask

    task automatic test_simultaneous();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'b100;
        exp_seq[1] = 3'b101;
        exp_seq[2] = 3'b110;
        ev_if.event_ready = 1'b1;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        checks++;
        if (frame_hits !== 3'b100) begin
            errors++;
            $display("FAIL simul_frame_hits: got %b expected 100", frame_hits);
        end
        sb = 1; th = 1; se = 1;
        tick();
        sb = 0; th = 0; se = 0;
        checks++;
        if (ev_if.event_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_pre: valid got %b expected 0", ev_if.event_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({ev_if.event_valid, ev_if.event_type} !== exp_seq[i]) begin
                errors++;
                $display("FAIL simul_beat%0d: got %b expected %b", i,
                         {ev_if.event_valid, ev_if.event_type}, exp_seq[i]);
            end
        end
        tick();
        checks++;
        if (ev_if.event_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_end: valid got %b expected 0", ev_if.event_valid);
        end
    endtask

    task automatic test_backpressure();
        ev_if.event_ready = 1'b0;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        checks++;
        if (frame_hits !== 3'b111) begin
            errors++;
            $display("FAIL bp_frame_hits: got %b expected 111", frame_hits);
        end
        th = 1; se = 1;
        tick();
        th = 0; se = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({ev_if.event_valid, ev_if.event_type} !== 3'b101) begin
                errors++;
                $display("FAIL bp_hold%0d: got %b expected 101", i, {ev_if.event_valid, ev_if.event_type});
            end
            if (i < 9) tick();
        end
        ev_if.event_ready = 1'b1;
        tick();
        checks++;
        if ({ev_if.event_valid, ev_if.event_type} !== 3'b110) begin
            errors++;
            $display("FAIL bp_next: got %b expected 110", {ev_if.event_valid, ev_if.event_type});
        end
        tick();
        checks++;
        if (ev_if.event_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: valid got %b expected 0", ev_if.event_valid);
        end
    endtask

    task automatic test_frame_boundary();
        int nvalid;
        ev_if.event_ready = 1'b1;
        sof = 1'b1;
        sb  = 1'b1;
        tick();
        sof = 1'b0;
        checks++;
        if (frame_hits !== 3'b110) begin
            errors++;
            $display("FAIL fb_frame_hits: got %b expected 110", frame_hits);
        end
        tick();
        checks++;
        if ({ev_if.event_valid, ev_if.event_type} !== 3'b100) begin
            errors++;
            $display("FAIL fb_event: got %b expected 100", {ev_if.event_valid, ev_if.event_type});
        end
        nvalid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ev_if.event_valid === 1'b1) nvalid++;
        end
        sb = 1'b0;
        checks++;
        if (nvalid != 0) begin
            errors++;
            $display("FAIL fb_repeat: got %0d extra events expected 0", nvalid);
        end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        checks++;
        if (frame_hits !== 3'b001) begin
            errors++;
            $display("FAIL fb_next_frame_hits: got %b expected 001", frame_hits);
        end
    endtask

    task automatic test_reset_mid_hold();
        ev_if.event_ready = 1'b0;
        se = 1'b1;
        tick();
        se = 1'b0;
        sof = 1'b1;
        tick();
        sof = 1'b0;
        tick();
        checks++;
        if ({ev_if.event_valid, ev_if.event_type, frame_hits} !== 6'b110100) begin
            errors++;
            $display("FAIL rst_pre: got %b expected 110100", {ev_if.event_valid, ev_if.event_type, frame_hits});
        end
        #3;
        resetN = 1'b0;
        #1;
        checks++;
        if ({ev_if.event_valid, ev_if.event_type, frame_hits} !== 6'b000000) begin
            errors++;
            $display("FAIL rst_async: got %b expected 000000", {ev_if.event_valid, ev_if.event_type, frame_hits});
        end
        resetN = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (ev_if.event_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_quiet%0d: valid got %b expected 0", i, ev_if.event_valid);
            end
        end
        th = 1'b1;
        tick();
        th = 1'b0;
        tick();
        checks++;
        if ({ev_if.event_valid, ev_if.event_type} !== 3'b101) begin
            errors++;
            $display("FAIL rst_recover: got %b expected 101", {ev_if.event_valid, ev_if.event_type});
        end
    endtask

`ifdef COLLISION_DROP_CNT_EN
    task automatic test_drop();
        // Type 1 is held (ready low); queue a ShotBox hit behind it
        sb = 1'b1;
        tick();
        sb = 1'b0;
        checks++;
        if (drop_count !== 8'd0) begin
            errors++;
            $display("FAIL drop_none: got %0d expected 0", drop_count);
        end
        for (int n = 1; n <= 300; n++) begin
            sof = 1'b1;
            sb  = 1'b1;
            tick();
            sof = 1'b0;
            sb  = 1'b0;
            if (n == 1 || n == 254 || n == 255 || n == 300) begin
                checks++;
                if (drop_count !== ((n > 255) ? 8'd255 : 8'(n))) begin
                    errors++;
                    $display("FAIL drop_count_%0d: got %0d expected %0d", n, drop_count,
                             (n > 255) ? 255 : n);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_hit();
        test_simultaneous();
        test_backpressure();
        test_frame_boundary();
        test_reset_mid_hold();
`ifdef COLLISION_DROP_CNT_EN
        test_drop();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
